// File: rtl/axi_ar_arbiter_pkg.sv
// axi_ar_arbiter_pkg: shared AXI read-channel widths and the arbiter FSM state type.
package axi_ar_arbiter_pkg;
   localparam int ID_W   = 4;
   localparam int ADDR_W = 32;
   localparam int LEN_W  = 8;
   localparam int SIZE_W = 3;
   localparam int DATA_W = 32;
   localparam int RESP_W = 2;
   typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_e;
endpackage

// File: rtl/axi_ar_arbiter_if.sv
// axi_ar_arbiter_if: N parallel AXI read ports (AR + R channels), element m is port m.
//   master modport: issues AR, accepts R (ar_* / ar_valid / r_ready out)
//   slave modport:  accepts AR, returns R (ar_ready / r_* / r_valid out)
interface axi_ar_arbiter_if
   import axi_ar_arbiter_pkg::*;
#(
   parameter int N = 1
) ();
   logic [N-1:0][ID_W-1:0]   ar_id;
   logic [N-1:0][ADDR_W-1:0] ar_addr;
   logic [N-1:0][LEN_W-1:0]  ar_len;
   logic [N-1:0][SIZE_W-1:0] ar_size;
   logic [N-1:0][1:0]        ar_burst;
   logic [N-1:0]             ar_valid;
   logic [N-1:0]             ar_ready;
   logic [N-1:0][ID_W-1:0]   r_id;
   logic [N-1:0][DATA_W-1:0] r_data;
   logic [N-1:0][RESP_W-1:0] r_resp;
   logic [N-1:0]             r_last;
   logic [N-1:0]             r_valid;
   logic [N-1:0]             r_ready;
   modport master (
      output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, r_ready,
      input  ar_ready, r_id, r_data, r_resp, r_last, r_valid
   );
   modport slave (
      input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, r_ready,
      output ar_ready, r_id, r_data, r_resp, r_last, r_valid
   );
endinterface

// File: rtl/axi_ar_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req     - request vector
//   last    - index granted most recently (lowest priority this round)
//   gnt_idx - first requester found searching from last+1, wrapping
//   gnt_vld - any request present
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] last,
   output logic [$clog2(N)-1:0] gnt_idx,
   output logic                 gnt_vld
);
   localparam int W = $clog2(N);
   logic [W-1:0] k;
   // Scan from the farthest candidate to the nearest so the nearest requester after last wins.
   always_comb begin
      gnt_idx = '0;
      gnt_vld = 1'b0;
      k = '0;
      for (int i = N; i > 0; i--) begin
         k = W'((int'(last) + i) % N);
         if (req[k]) begin
            gnt_idx = k;
            gnt_vld = 1'b1;
         end
      end
   end
endmodule

// File: rtl/axi_ar_arbiter.sv
// axi_ar_arbiter: shares one slave read port among NUM_M masters, one burst at a time, round-robin.
//   clk   - AXI clock, rising edge
//   rst   - asynchronous active-high reset
//   m     - NUM_M master-facing read ports (arbiter acts as their slave)
//   s     - single slave-facing read port (arbiter acts as its master)
//   grant - one-hot current owner, 0 while idle
module axi_ar_arbiter
   import axi_ar_arbiter_pkg::*;
#(
   parameter int NUM_M = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   axi_ar_arbiter_if.slave       m,
   axi_ar_arbiter_if.master      s,
   output logic [NUM_M-1:0]      grant
);
   localparam int MW = $clog2(NUM_M);
   arb_state_e state, state_n;
   logic [MW-1:0] owner, last_grant, gnt_idx;
   logic gnt_vld;
   rr_arbiter #(.N(NUM_M)) u_rr (
      .req(m.ar_valid),
      .last(last_grant),
      .gnt_idx(gnt_idx),
      .gnt_vld(gnt_vld)
   );
   // Owner is captured when leaving IDLE and held until the RLAST handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         owner <= '0;
         last_grant <= MW'(NUM_M - 1);
      end else begin
         state <= state_n;
         if (state == IDLE && gnt_vld) owner <= gnt_idx;
         if (state == DATA && state_n == IDLE) last_grant <= owner;
      end
   end
   // All outputs derive from state, so an asynchronous reset zeroes them at once.
   always_comb begin
      grant = '0;
      m.ar_ready = '0;
      m.r_id = '0;
      m.r_data = '0;
      m.r_resp = '0;
      m.r_last = '0;
      m.r_valid = '0;
      s.ar_id = '0;
      s.ar_addr = '0;
      s.ar_len = '0;
      s.ar_size = '0;
      s.ar_burst = '0;
      s.ar_valid = '0;
      s.r_ready = '0;
      if (state != IDLE) grant[owner] = 1'b1;
      if (state == ADDR) begin
         s.ar_id[0] = m.ar_id[owner];
         s.ar_addr[0] = m.ar_addr[owner];
         s.ar_len[0] = m.ar_len[owner];
         s.ar_size[0] = m.ar_size[owner];
         s.ar_burst[0] = m.ar_burst[owner];
         s.ar_valid[0] = m.ar_valid[owner];
         m.ar_ready[owner] = s.ar_ready[0];
      end
      if (state == DATA) begin
         m.r_id[owner] = s.r_id[0];
         m.r_data[owner] = s.r_data[0];
         m.r_resp[owner] = s.r_resp[0];
         m.r_last[owner] = s.r_last[0];
         m.r_valid[owner] = s.r_valid[0];
         s.r_ready[0] = m.r_ready[owner];
      end
      state_n = state == IDLE ? (gnt_vld ? ADDR : IDLE)
              : state == ADDR ? (s.ar_valid[0] && s.ar_ready[0] ? DATA : ADDR)
              : (s.r_valid[0] && s.r_ready[0] && s.r_last[0] ? IDLE : DATA);
   end
endmodule
